// File: rtl/contribution_scheduler.sv
// Column search for OMP: correlates y with each column of a fixed 3x4 matrix A
// over one shared multiplier and adder, reporting the unmasked column of largest magnitude.
module contribution_scheduler #(
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [95:0] buff_y,
  input  logic [3:0]  col_mask,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s,
  output logic [1:0]  column_no,
  output logic [31:0] max_val,
  output logic        none_valid,
  output logic        done
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COL_START = 3'd1;
  localparam logic [2:0] MUL_ISSUE = 3'd2;
  localparam logic [2:0] MUL_WAIT  = 3'd3;
  localparam logic [2:0] ADD_ISSUE = 3'd4;
  localparam logic [2:0] ADD_WAIT  = 3'd5;
  localparam logic [2:0] COMPARE   = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  logic [2:0]  state;
  logic [95:0] y_q;
  logic [3:0]  msk;
  logic [1:0]  j, r;
  logic [7:0]  wcnt;
  logic [31:0] acc, prod, best;
  logic [1:0]  bidx;
  logic        found;

  function automatic logic [31:0] a_coef(input logic [1:0] rr, input logic [1:0] cc);
    case ({rr, cc})
      4'h0: a_coef = 32'h3f000000;  //  0.5
      4'h1: a_coef = 32'hbfc00000;  // -1.5
      4'h2: a_coef = 32'hbf400000;  // -0.75
      4'h3: a_coef = 32'hbf600000;  // -0.875
      4'h4: a_coef = 32'h3f400000;  //  0.75
      4'h5: a_coef = 32'h3f000000;  //  0.5
      4'h6: a_coef = 32'hbf400000;  // -0.75
      4'h7: a_coef = 32'hbfa00000;  // -1.25
      4'h8: a_coef = 32'h3f400000;  //  0.75
      4'h9: a_coef = 32'hbe000000;  // -0.125
      4'ha: a_coef = 32'h3fb00000;  //  1.375
      4'hb: a_coef = 32'h3e800000;  //  0.25
      default: a_coef = 32'h0;
    endcase
  endfunction

  logic [31:0] y_sel, mag, best_n;
  logic [1:0]  bidx_n;
  logic        upd, found_n, last;
  logic [2:0]  col_next;

  always_comb begin
    case (r)
      2'd0:    y_sel = y_q[95:64];
      2'd1:    y_sel = y_q[63:32];
      default: y_sel = y_q[31:0];
    endcase
    mag     = {1'b0, acc[30:0]};
    upd     = (state == COMPARE) && (!found || (mag > best));
    best_n  = upd ? mag : best;
    bidx_n  = upd ? j : bidx;
    found_n = found | upd;
    last    = (j == 2'd3);
    // Masked columns park one cycle in COL_START; unmasked ones go straight to the first multiply.
    col_next = last ? DONE : (msk[j + 2'd1] ? COL_START : MUL_ISSUE);
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign mul_a = (state == MUL_ISSUE || state == MUL_WAIT) ? a_coef(r, j) : 32'h0;
  assign mul_b = (state == MUL_ISSUE || state == MUL_WAIT) ? y_sel : 32'h0;
  assign add_a = (state == ADD_ISSUE || state == ADD_WAIT) ? acc : 32'h0;
  assign add_b = (state == ADD_ISSUE || state == ADD_WAIT) ? prod : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; y_q <= '0; msk <= '0; j <= '0; r <= '0; wcnt <= '0;
      acc <= '0; prod <= '0; best <= '0; bidx <= '0; found <= 1'b0;
      column_no <= '0; max_val <= '0; none_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          y_q <= buff_y; msk <= col_mask; j <= '0; r <= '0;
          found <= 1'b0; best <= '0; bidx <= '0;
          state <= col_mask[0] ? COL_START : MUL_ISSUE;
        end
        MUL_ISSUE: begin wcnt <= 8'd1; state <= MUL_WAIT; end
        MUL_WAIT: if (wcnt == 8'(MUL_LAT)) begin
          if (r == 2'd0) begin
            acc <= mul_p; r <= 2'd1; state <= MUL_ISSUE;
          end else begin
            prod <= mul_p; state <= ADD_ISSUE;
          end
        end else wcnt <= wcnt + 8'd1;
        ADD_ISSUE: begin wcnt <= 8'd1; state <= ADD_WAIT; end
        ADD_WAIT: if (wcnt == 8'(ADD_LAT)) begin
          acc <= add_s;
          if (r == 2'd2) state <= COMPARE;
          else begin r <= r + 2'd1; state <= MUL_ISSUE; end
        end else wcnt <= wcnt + 8'd1;
        COL_START, COMPARE: begin
          best <= best_n; bidx <= bidx_n; found <= found_n;
          state <= col_next;
          if (last) begin
            column_no <= bidx_n; max_val <= best_n; none_valid <= !found_n;
          end else begin
            j <= j + 2'd1; r <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
